hazard_ctrl: RTL and testbench

//  Pipeline hazard controller: generates d_h (bubble/flush) for the ID/EX register, plus stall/flush for PC and IF/ID.

---
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard inputs toward the controller,
// pipeline stall/flush/freeze controls and status back out.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_re;
    logic        ex_RegWrite;
    logic [4:0]  ex_write_reg;
    logic        branch_taken;
    logic        ex_Jump;
    logic        mem_busy;
    logic        d_h;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        pipe_freeze;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_re, ex_RegWrite, ex_write_reg,
               branch_taken, ex_Jump, mem_busy,
        input  d_h, pc_stall, if_id_stall, if_id_flush, pipe_freeze,
               mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_re, ex_RegWrite, ex_write_reg,
               branch_taken, ex_Jump, mem_busy,
        output d_h, pc_stall, if_id_stall, if_id_flush, pipe_freeze,
               mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes and
// data-memory wait freezes, with a sticky memory timeout and a stall counter.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int MEM_TIMEOUT       = 16
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} state_t;

    localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

    state_t      state, state_nxt, resume, resume_nxt, eff;
    logic [1:0]  cnt, cnt_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        timeout_set;
    logic        load_use, redirect;
    logic        d_h, pc_stall, if_id_stall, if_id_flush, pipe_freeze;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign load_use = bus.ex_re && bus.ex_RegWrite && (bus.ex_write_reg != 5'd0) &&
                      ((bus.ex_write_reg == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_write_reg == bus.id_rt)));
    assign redirect = bus.branch_taken || bus.ex_Jump;

    always_comb begin
        // Once memory answers, the wait behaves as the state it interrupted.
        eff          = (state == MEM_WAIT && !bus.mem_busy) ? resume : state;
        state_nxt    = eff;
        resume_nxt   = resume;
        cnt_nxt      = cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        d_h          = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        pipe_freeze  = 1'b0;

        if (reset) begin
            state_nxt = RUN;
        end else if (eff == MEM_WAIT) begin
            if (wait_cnt >= TMO) begin
                timeout_set  = 1'b1;
                state_nxt    = RUN;
                cnt_nxt      = 2'd0;
                wait_cnt_nxt = 8'd0;
            end else begin
                pipe_freeze  = 1'b1;
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                wait_cnt_nxt = wait_cnt + 8'd1;
            end
        end else if (bus.mem_busy) begin
            pipe_freeze  = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            wait_cnt_nxt = 8'd1;
            resume_nxt   = eff;
            state_nxt    = MEM_WAIT;
        end else if (eff == FLUSH) begin
            d_h         = 1'b1;
            if_id_flush = 1'b1;
            if (cnt <= 2'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt - 2'd1;
            end
        end else if (redirect) begin
            // A redirect also abandons any load stall in progress.
            d_h         = 1'b1;
            if_id_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FL_INIT;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        end else if (eff == LOAD_STALL) begin
            d_h         = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            if (cnt <= 2'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt - 2'd1;
            end
        end else if (load_use) begin
            d_h         = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nxt = LOAD_STALL;
                cnt_nxt   = LS_INIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            resume       <= RUN;
            cnt          <= 2'd0;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state    <= state_nxt;
            resume   <= resume_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (pc_stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

    assign bus.d_h          = d_h;
    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.pipe_freeze  = pipe_freeze;
    assign bus.mem_timeout  = mem_timeout;
    assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default instance and a (2,3,4)-parameter instance
// share one directed stimulus and are checked against an obligation-count model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       re;
        logic       rw;
        logic [4:0] wr;
        logic       br;
        logic       jmp;
        logic       busy;
    } in_t;

    // Output vector order: {d_h, pc_stall, if_id_stall, if_id_flush, pipe_freeze}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11100;
    localparam logic [4:0] O_FLUSH = 5'b10010;
    localparam logic [4:0] O_FRZ   = 5'b01101;
    localparam in_t        IDLE    = '0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    in_t  cur   = '0;
    bit   armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hazard_ctrl_if hif0 ();
    hazard_ctrl_if hif1 ();

    assign hif0.id_rs = cur.rs;        assign hif1.id_rs = cur.rs;
    assign hif0.id_rt = cur.rt;        assign hif1.id_rt = cur.rt;
    assign hif0.id_uses_rt = cur.urt;  assign hif1.id_uses_rt = cur.urt;
    assign hif0.ex_re = cur.re;        assign hif1.ex_re = cur.re;
    assign hif0.ex_RegWrite = cur.rw;  assign hif1.ex_RegWrite = cur.rw;
    assign hif0.ex_write_reg = cur.wr; assign hif1.ex_write_reg = cur.wr;
    assign hif0.branch_taken = cur.br; assign hif1.branch_taken = cur.br;
    assign hif0.ex_Jump = cur.jmp;     assign hif1.ex_Jump = cur.jmp;
    assign hif0.mem_busy = cur.busy;   assign hif1.mem_busy = cur.busy;

    hazard_ctrl u_def (
        .clock (clock),
        .reset (reset),
        .bus   (hif0.slave)
    );

    hazard_ctrl #(
        .LOAD_STALL_CYCLES (2),
        .FLUSH_CYCLES      (3),
        .MEM_TIMEOUT       (4)
    ) u_alt (
        .clock (clock),
        .reset (reset),
        .bus   (hif1.slave)
    );

    logic [4:0]  dout [2];
    logic [31:0] sc   [2];
    logic        mt   [2];
    assign dout[0] = {hif0.d_h, hif0.pc_stall, hif0.if_id_stall, hif0.if_id_flush, hif0.pipe_freeze};
    assign dout[1] = {hif1.d_h, hif1.pc_stall, hif1.if_id_stall, hif1.if_id_flush, hif1.pipe_freeze};
    assign sc[0] = hif0.stall_cycles;
    assign sc[1] = hif1.stall_cycles;
    assign mt[0] = hif0.mem_timeout;
    assign mt[1] = hif1.mem_timeout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: pending bubble/flush obligations plus a run length of busy cycles.
    int          p_ls [2] = '{1, 2};
    int          p_fl [2] = '{1, 3};
    int          p_to [2] = '{16, 4};
    int          m_stall [2] = '{0, 0};
    int          m_flush [2] = '{0, 0};
    int          m_busy  [2] = '{0, 0};
    logic        m_tmo   [2] = '{1'b0, 1'b0};
    logic [31:0] m_sc    [2] = '{32'd0, 32'd0};

    always @(negedge clock) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] e;
                logic       lu;
                logic       rd;
                e  = O_IDLE;
                lu = cur.re && cur.rw && (cur.wr != 5'd0) &&
                     ((cur.wr == cur.rs) || (cur.urt && (cur.wr == cur.rt)));
                rd = cur.br || cur.jmp;
                chk($sformatf("stall_cycles_u%0d", k), sc[k], m_sc[k]);
                chk($sformatf("mem_timeout_u%0d", k), {31'd0, mt[k]}, {31'd0, m_tmo[k]});
                if (reset) begin
                    m_stall[k] = 0;
                    m_flush[k] = 0;
                    m_busy[k]  = 0;
                    m_tmo[k]   = 1'b0;
                end else if (cur.busy && m_busy[k] < p_to[k]) begin
                    e = O_FRZ;
                    m_busy[k]++;
                end else if (cur.busy) begin
                    m_tmo[k]   = 1'b1;
                    m_busy[k]  = 0;
                    m_stall[k] = 0;
                    m_flush[k] = 0;
                end else begin
                    m_busy[k] = 0;
                    if (m_flush[k] > 0) begin
                        e = O_FLUSH;
                        m_flush[k]--;
                    end else if (rd) begin
                        e = O_FLUSH;
                        m_flush[k] = p_fl[k] - 1;
                        m_stall[k] = 0;
                    end else if (m_stall[k] > 0) begin
                        e = O_STALL;
                        m_stall[k]--;
                    end else if (lu) begin
                        e = O_STALL;
                        m_stall[k] = p_ls[k] - 1;
                    end
                end
                chk($sformatf("outputs_u%0d", k), {27'd0, dout[k]}, {27'd0, e});
                if (reset) begin
                    m_sc[k] = 32'd0;
                end else if (e[3]) begin
                    m_sc[k] = (m_sc[k] == 32'hFFFF_FFFF) ? m_sc[k] : m_sc[k] + 32'd1;
                end
            end
        end
    end

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic re, input logic rw, input logic [4:0] wr,
                               input logic br, input logic jmp, input logic busy);
        in_t v;
        v = '{rs: rs, rt: rt, urt: urt, re: re, rw: rw, wr: wr, br: br, jmp: jmp, busy: busy};
        return v;
    endfunction

    task automatic cyc(input in_t v, input logic r);
        @(posedge clock);
        #1;
        cur   = v;
        reset = r;
        @(negedge clock);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    in_t lw5, lw0, lw7_rt, lw7_nort, alu7, br_lu, jmp, busy;

    initial begin
        lw5      = mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        lw0      = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        lw7_rt   = mk(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        lw7_nort = mk(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        alu7     = mk(5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        br_lu    = mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        jmp      = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        busy     = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        #1 armed = 1'b1;
        cyc(IDLE, 1'b1);
        lit("reset_out", {27'd0, dout[0]}, 32'd0);
        lit("reset_sc", sc[0], 32'd0);
        cyc(IDLE, 1'b1);
        cyc(IDLE, 1'b0);

        // Single load-use: one bubble by default, two with LOAD_STALL_CYCLES=2
        cyc(lw5, 1'b0);
        lit("lu_stall_u0", {27'd0, dout[0]}, {27'd0, O_STALL});
        lit("lu_stall_u1", {27'd0, dout[1]}, {27'd0, O_STALL});
        cyc(IDLE, 1'b0);
        lit("lu_done_u0", {27'd0, dout[0]}, {27'd0, O_IDLE});
        lit("lu_sc_u0", sc[0], 32'd1);
        lit("lu_second_u1", {27'd0, dout[1]}, {27'd0, O_STALL});
        cyc(IDLE, 1'b0);
        lit("lu_done_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        lit("lu_sc_u1", sc[1], 32'd2);

        // $0 destination, rt without id_uses_rt and a non-load writer never stall
        cyc(lw0, 1'b0);
        lit("lw0_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        cyc(lw7_nort, 1'b0);
        lit("nort_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        cyc(alu7, 1'b0);
        lit("alu_u0", {27'd0, dout[0]}, {27'd0, O_IDLE});
        cyc(lw7_rt, 1'b0);
        lit("rt_stall_u1", {27'd0, dout[1]}, {27'd0, O_STALL});
        cyc(IDLE, 1'b0);
        lit("rt_second_u1", {27'd0, dout[1]}, {27'd0, O_STALL});
        cyc(IDLE, 1'b0);
        lit("rt_done_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});

        // Branch beats load-use in the same cycle
        cyc(br_lu, 1'b0);
        lit("br_u0", {27'd0, dout[0]}, {27'd0, O_FLUSH});
        lit("br_u1", {27'd0, dout[1]}, {27'd0, O_FLUSH});
        cyc(IDLE, 1'b0);
        lit("br_after_u0", {27'd0, dout[0]}, {27'd0, O_IDLE});
        lit("br_flush2_u1", {27'd0, dout[1]}, {27'd0, O_FLUSH});
        cyc(IDLE, 1'b0);
        lit("br_flush3_u1", {27'd0, dout[1]}, {27'd0, O_FLUSH});
        cyc(IDLE, 1'b0);
        lit("br_done_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        cyc(jmp, 1'b0);
        lit("jmp_u0", {27'd0, dout[0]}, {27'd0, O_FLUSH});
        for (int i = 0; i < 3; i++) cyc(IDLE, 1'b0);

        // Three-cycle memory wait
        cyc(IDLE, 1'b1);
        cyc(IDLE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(busy, 1'b0);
            lit("busy_frz_u0", {27'd0, dout[0]}, {27'd0, O_FRZ});
        end
        cyc(IDLE, 1'b0);
        lit("busy_done_u0", {27'd0, dout[0]}, {27'd0, O_IDLE});
        lit("busy_sc_u0", sc[0], 32'd3);
        lit("busy_sc_u1", sc[1], 32'd3);

        // Memory wait in the middle of a two-cycle load stall resumes the stall
        cyc(lw5, 1'b0);
        cyc(busy, 1'b0);
        cyc(busy, 1'b0);
        cyc(IDLE, 1'b0);
        lit("resume_u1", {27'd0, dout[1]}, {27'd0, O_STALL});
        lit("resume_u0", {27'd0, dout[0]}, {27'd0, O_IDLE});
        cyc(IDLE, 1'b0);
        lit("resume_done_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});

        // Stuck memory: MEM_TIMEOUT=4 instance releases and flags
        cyc(IDLE, 1'b1);
        cyc(IDLE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(busy, 1'b0);
            lit("tmo_frz_u1", {27'd0, dout[1]}, {27'd0, O_FRZ});
        end
        cyc(busy, 1'b0);
        lit("tmo_release_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        lit("tmo_flag_pre_u1", {31'd0, mt[1]}, 32'd0);
        cyc(busy, 1'b0);
        lit("tmo_flag_u1", {31'd0, mt[1]}, 32'd1);
        cyc(IDLE, 1'b0);
        lit("tmo_sticky_u1", {31'd0, mt[1]}, 32'd1);
        lit("tmo_none_u0", {31'd0, mt[0]}, 32'd0);
        cyc(IDLE, 1'b1);
        cyc(IDLE, 1'b0);
        lit("tmo_clear_u1", {31'd0, mt[1]}, 32'd0);

        // Reset during the second cycle of a three-cycle flush
        cyc(jmp, 1'b0);
        lit("rflush_u1", {27'd0, dout[1]}, {27'd0, O_FLUSH});
        cyc(IDLE, 1'b1);
        lit("rflush_rst_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        cyc(IDLE, 1'b0);
        lit("rflush_after_u1", {27'd0, dout[1]}, {27'd0, O_IDLE});
        lit("rflush_sc_u1", sc[1], 32'd0);

        // Redirect abandons a load stall in progress
        cyc(lw5, 1'b0);
        cyc(br_lu, 1'b0);
        lit("abandon_u1", {27'd0, dout[1]}, {27'd0, O_FLUSH});
        for (int i = 0; i < 4; i++) cyc(IDLE, 1'b0);

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
